// File: rtl/bitstream_ring_buffer.sv
// Circular word buffer between the bitstream loader and the decoder fetch logic.
// Concurrent write/read, 1- or 2-cycle read latency, level/watermark, flush, sticky error flags.
module bitstream_ring_buffer #(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned RD_LATENCY = 1,
  parameter int unsigned LOW_WM     = 64,
  parameter int unsigned SWAP_BYTES = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  output logic              full,
  input  logic              rd_req,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              empty,
  output logic [ADDR_W:0]   level,
  output logic              refill_req,
  output logic              overflow,
  output logic              underflow
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam int unsigned LVL_W = ADDR_W + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [LVL_W-1:0]  wr_ptr;
  logic [LVL_W-1:0]  rd_ptr;
  logic [LVL_W-1:0]  level_next;
  logic              wr_acc;
  logic              rd_acc;
  logic [DATA_W-1:0] mem_rd;

  // Output byte order; identity unless SWAP_BYTES is set.
  function automatic logic [DATA_W-1:0] out_map(input logic [DATA_W-1:0] w);
    logic [DATA_W-1:0] r;
    r = w;
    if (SWAP_BYTES != 0) begin
      for (int i = 0; i < int'(DATA_W / 8); i++) begin
        r[8*i +: 8] = w[int'(DATA_W) - 8 - 8*i +: 8];
      end
    end
    return r;
  endfunction

  // Acceptance uses the registered full/empty from the start of the cycle.
  always_comb begin
    wr_acc     = wr_en && !full;
    rd_acc     = rd_req && !empty;
    level_next = level + LVL_W'(wr_acc) - LVL_W'(rd_acc);
  end

  assign mem_rd = mem[rd_ptr[ADDR_W-1:0]];

  // Storage is never cleared; only accepted writes touch it.
  always_ff @(posedge clk) begin
    if (!reset && !flush && wr_acc) begin
      mem[wr_ptr[ADDR_W-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      empty      <= 1'b1;
      full       <= 1'b0;
      refill_req <= 1'b1;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + LVL_W'(1);
      if (rd_acc) rd_ptr <= rd_ptr + LVL_W'(1);
      level      <= level_next;
      empty      <= (level_next == LVL_W'(0));
      full       <= (level_next == LVL_W'(DEPTH));
      refill_req <= (level_next <= LVL_W'(LOW_WM));
      if (wr_en && full)   overflow  <= 1'b1;
      if (rd_req && empty) underflow <= 1'b1;
    end
  end

  // Read pipeline; rd_data only moves with a valid word, flush kills in-flight valids.
  if (RD_LATENCY == 2) begin : g_lat2
    logic              p1_valid;
    logic [DATA_W-1:0] p1_data;

    always_ff @(posedge clk) begin
      if (reset) begin
        p1_valid <= 1'b0;
        rd_valid <= 1'b0;
        rd_data  <= '0;
      end else if (flush) begin
        p1_valid <= 1'b0;
        rd_valid <= 1'b0;
      end else begin
        p1_valid <= rd_acc;
        if (rd_acc) p1_data <= mem_rd;
        rd_valid <= p1_valid;
        if (p1_valid) rd_data <= out_map(p1_data);
      end
    end
  end else begin : g_lat1
    always_ff @(posedge clk) begin
      if (reset) begin
        rd_valid <= 1'b0;
        rd_data  <= '0;
      end else if (flush) begin
        rd_valid <= 1'b0;
      end else begin
        rd_valid <= rd_acc;
        if (rd_acc) rd_data <= out_map(mem_rd);
      end
    end
  end

endmodule

// File: tb/tb_bitstream_ring_buffer.sv
// Directed bench: instance a (depth 16, latency 1, LOW_WM 4), instance b (latency 2, byte swap).
module tb_bitstream_ring_buffer;

  logic        clk;
  logic        reset;

  logic        flush_a, wr_en_a, rd_req_a;
  logic [15:0] wr_data_a, rd_data_a;
  logic        full_a, rd_valid_a, empty_a, refill_a, overflow_a, underflow_a;
  logic [4:0]  level_a;

  logic        flush_b, wr_en_b, rd_req_b;
  logic [15:0] wr_data_b, rd_data_b;
  logic        full_b, rd_valid_b, empty_b, refill_b, overflow_b, underflow_b;
  logic [4:0]  level_b;

  int n_cmp;
  int n_bad;

  bitstream_ring_buffer #(
    .DATA_W(16), .ADDR_W(4), .RD_LATENCY(1), .LOW_WM(4), .SWAP_BYTES(0)
  ) dut_a (
    .clk(clk), .reset(reset), .flush(flush_a), .wr_en(wr_en_a), .wr_data(wr_data_a),
    .full(full_a), .rd_req(rd_req_a), .rd_data(rd_data_a), .rd_valid(rd_valid_a),
    .empty(empty_a), .level(level_a), .refill_req(refill_a), .overflow(overflow_a),
    .underflow(underflow_a)
  );

  bitstream_ring_buffer #(
    .DATA_W(16), .ADDR_W(4), .RD_LATENCY(2), .LOW_WM(4), .SWAP_BYTES(1)
  ) dut_b (
    .clk(clk), .reset(reset), .flush(flush_b), .wr_en(wr_en_b), .wr_data(wr_data_b),
    .full(full_b), .rd_req(rd_req_b), .rd_data(rd_data_b), .rd_valid(rd_valid_b),
    .empty(empty_b), .level(level_b), .refill_req(refill_b), .overflow(overflow_b),
    .underflow(underflow_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge; inputs change and outputs are sampled 1ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    flush_a = 0; wr_en_a = 0; rd_req_a = 0; wr_data_a = '0;
    flush_b = 0; wr_en_b = 0; rd_req_b = 0; wr_data_b = '0;
    step(); step();
    n_cmp++; if (level_a !== 5'd0) begin n_bad++; $display("FAIL reset_level: got %0d want 0", level_a); end
    n_cmp++; if (empty_a !== 1'b1) begin n_bad++; $display("FAIL reset_empty: got %b want 1", empty_a); end
    n_cmp++; if (full_a !== 1'b0) begin n_bad++; $display("FAIL reset_full: got %b want 0", full_a); end
    n_cmp++; if (refill_a !== 1'b1) begin n_bad++; $display("FAIL reset_refill: got %b want 1", refill_a); end
    n_cmp++; if (rd_valid_a !== 1'b0) begin n_bad++; $display("FAIL reset_rd_valid: got %b want 0", rd_valid_a); end
    n_cmp++; if (rd_data_a !== 16'h0000) begin n_bad++; $display("FAIL reset_rd_data_a: got %h want 0000", rd_data_a); end
    n_cmp++; if (rd_data_b !== 16'h0000) begin n_bad++; $display("FAIL reset_rd_data_b: got %h want 0000", rd_data_b); end
    n_cmp++; if ({overflow_a, underflow_a} !== 2'b00) begin n_bad++; $display("FAIL reset_flags: got %b want 00", {overflow_a, underflow_a}); end
    reset = 1'b0;
    step();
  endtask

  task automatic test_basic_order();
    for (int i = 1; i <= 5; i++) begin
      wr_en_a = 1'b1; wr_data_a = 16'(i);
      step();
    end
    wr_en_a = 1'b0;
    n_cmp++; if (level_a !== 5'd5) begin n_bad++; $display("FAIL basic_level_filled: got %0d want 5", level_a); end
    for (int i = 1; i <= 5; i++) begin
      rd_req_a = 1'b1;
      step();
      n_cmp++; if (rd_valid_a !== 1'b1) begin n_bad++; $display("FAIL basic_rd_valid[%0d]: got %b want 1", i, rd_valid_a); end
      n_cmp++; if (rd_data_a !== 16'(i)) begin n_bad++; $display("FAIL basic_rd_data[%0d]: got %h want %h", i, rd_data_a, 16'(i)); end
      n_cmp++; if (level_a !== 5'(5 - i)) begin n_bad++; $display("FAIL basic_level[%0d]: got %0d want %0d", i, level_a, 5 - i); end
    end
    rd_req_a = 1'b0;
    step();
    n_cmp++; if (rd_valid_a !== 1'b0) begin n_bad++; $display("FAIL basic_rd_valid_end: got %b want 0", rd_valid_a); end
    n_cmp++; if (empty_a !== 1'b1) begin n_bad++; $display("FAIL basic_empty_end: got %b want 1", empty_a); end
  endtask

  task automatic test_full_boundary();
    for (int i = 0; i < 16; i++) begin
      wr_en_a = 1'b1; wr_data_a = 16'h0100 + 16'(i);
      step();
      if (i == 14) begin
        n_cmp++; if (full_a !== 1'b0) begin n_bad++; $display("FAIL full_early: got %b want 0", full_a); end
      end
    end
    n_cmp++; if (full_a !== 1'b1) begin n_bad++; $display("FAIL full_at_16: got %b want 1", full_a); end
    n_cmp++; if (level_a !== 5'd16) begin n_bad++; $display("FAIL full_level: got %0d want 16", level_a); end
    n_cmp++; if (refill_a !== 1'b0) begin n_bad++; $display("FAIL full_refill: got %b want 0", refill_a); end
    wr_data_a = 16'h01FF;
    step();
    wr_en_a = 1'b0;
    n_cmp++; if (overflow_a !== 1'b1) begin n_bad++; $display("FAIL full_overflow: got %b want 1", overflow_a); end
    n_cmp++; if (level_a !== 5'd16) begin n_bad++; $display("FAIL full_level_after_drop: got %0d want 16", level_a); end
    // Simultaneous write and read at full: read wins, write dropped.
    wr_en_a = 1'b1; wr_data_a = 16'h02AA; rd_req_a = 1'b1;
    step();
    wr_en_a = 1'b0;
    n_cmp++; if (rd_valid_a !== 1'b1) begin n_bad++; $display("FAIL simul_rd_valid: got %b want 1", rd_valid_a); end
    n_cmp++; if (rd_data_a !== 16'h0100) begin n_bad++; $display("FAIL simul_rd_data: got %h want 0100", rd_data_a); end
    n_cmp++; if (level_a !== 5'd15) begin n_bad++; $display("FAIL simul_level: got %0d want 15", level_a); end
    n_cmp++; if (overflow_a !== 1'b1) begin n_bad++; $display("FAIL simul_overflow: got %b want 1", overflow_a); end
    for (int i = 1; i < 16; i++) begin
      step();
      n_cmp++; if (rd_data_a !== 16'h0100 + 16'(i)) begin n_bad++; $display("FAIL full_drain[%0d]: got %h want %h", i, rd_data_a, 16'h0100 + 16'(i)); end
    end
    rd_req_a = 1'b0;
    step();
    n_cmp++; if (empty_a !== 1'b1) begin n_bad++; $display("FAIL full_drain_empty: got %b want 1", empty_a); end
    flush_a = 1'b1;
    step();
    flush_a = 1'b0;
    n_cmp++; if (overflow_a !== 1'b0) begin n_bad++; $display("FAIL flush_clears_overflow: got %b want 0", overflow_a); end
  endtask

  task automatic test_empty_boundary();
    rd_req_a = 1'b1; wr_en_a = 1'b1; wr_data_a = 16'hBEEF;
    step();
    wr_en_a = 1'b0;
    n_cmp++; if (rd_valid_a !== 1'b0) begin n_bad++; $display("FAIL empty_no_valid: got %b want 0", rd_valid_a); end
    n_cmp++; if (underflow_a !== 1'b1) begin n_bad++; $display("FAIL empty_underflow: got %b want 1", underflow_a); end
    n_cmp++; if (level_a !== 5'd1) begin n_bad++; $display("FAIL empty_level: got %0d want 1", level_a); end
    step();
    rd_req_a = 1'b0;
    n_cmp++; if (rd_valid_a !== 1'b1) begin n_bad++; $display("FAIL empty_next_valid: got %b want 1", rd_valid_a); end
    n_cmp++; if (rd_data_a !== 16'hBEEF) begin n_bad++; $display("FAIL empty_next_data: got %h want beef", rd_data_a); end
    step();
    n_cmp++; if (rd_data_a !== 16'hBEEF) begin n_bad++; $display("FAIL rd_data_hold: got %h want beef", rd_data_a); end
    n_cmp++; if (underflow_a !== 1'b1) begin n_bad++; $display("FAIL underflow_sticky: got %b want 1", underflow_a); end
    flush_a = 1'b1;
    step();
    flush_a = 1'b0;
  endtask

  task automatic test_wrap();
    logic [15:0] q[$];
    logic [15:0] exp_d;
    int lvl, written, cyc;
    bit filling, we, re;
    lvl = 0; written = 0; cyc = 0; filling = 1'b1;
    while ((written < 40 || lvl > 0) && cyc < 300) begin
      if (written >= 40) filling = 1'b0;
      else if (filling && lvl >= 10) filling = 1'b0;
      else if (!filling && lvl <= 3) filling = 1'b1;
      we = filling;
      re = (!filling && lvl > 0) || (filling && lvl >= 3 && (cyc % 4) == 3);
      wr_en_a = we; rd_req_a = re; wr_data_a = 16'h5000 + 16'(written);
      step();
      if (re) begin
        exp_d = q.pop_front();
        n_cmp++; if (rd_valid_a !== 1'b1 || rd_data_a !== exp_d) begin n_bad++; $display("FAIL wrap_data[%0d]: got v=%b %h want v=1 %h", cyc, rd_valid_a, rd_data_a, exp_d); end
      end else begin
        n_cmp++; if (rd_valid_a !== 1'b0) begin n_bad++; $display("FAIL wrap_idle_valid[%0d]: got %b want 0", cyc, rd_valid_a); end
      end
      if (we) begin
        q.push_back(16'h5000 + 16'(written));
        written++;
      end
      lvl = lvl + int'(we) - int'(re);
      n_cmp++; if (level_a !== 5'(lvl)) begin n_bad++; $display("FAIL wrap_level[%0d]: got %0d want %0d", cyc, level_a, lvl); end
      n_cmp++; if (refill_a !== (lvl <= 4)) begin n_bad++; $display("FAIL wrap_refill[%0d]: got %b want %b", cyc, refill_a, (lvl <= 4)); end
      cyc++;
    end
    wr_en_a = 1'b0; rd_req_a = 1'b0;
    n_cmp++; if (cyc >= 300) begin n_bad++; $display("FAIL wrap_timeout: got %0d cycles want < 300", cyc); end
  endtask

  task automatic test_latency_flush();
    wr_en_b = 1'b1; wr_data_b = 16'h1234;
    step();
    wr_en_b = 1'b0; rd_req_b = 1'b1;
    step();
    rd_req_b = 1'b0;
    n_cmp++; if (rd_valid_b !== 1'b0) begin n_bad++; $display("FAIL lat2_early_valid: got %b want 0", rd_valid_b); end
    step();
    n_cmp++; if (rd_valid_b !== 1'b1) begin n_bad++; $display("FAIL lat2_valid: got %b want 1", rd_valid_b); end
    n_cmp++; if (rd_data_b !== 16'h3412) begin n_bad++; $display("FAIL lat2_swap_data: got %h want 3412", rd_data_b); end
    step();
    n_cmp++; if (rd_valid_b !== 1'b0) begin n_bad++; $display("FAIL lat2_pulse_width: got %b want 0", rd_valid_b); end
    rd_req_b = 1'b1;
    step();
    rd_req_b = 1'b0;
    n_cmp++; if (underflow_b !== 1'b1) begin n_bad++; $display("FAIL lat2_underflow: got %b want 1", underflow_b); end
    wr_en_b = 1'b1; wr_data_b = 16'h1234;
    step();
    wr_en_b = 1'b0; rd_req_b = 1'b1;
    step();
    // Flush one cycle after acceptance, with requests that must be ignored.
    flush_b = 1'b1; wr_en_b = 1'b1; rd_req_b = 1'b1; wr_data_b = 16'hAAAA;
    step();
    flush_b = 1'b0; wr_en_b = 1'b0; rd_req_b = 1'b0;
    n_cmp++; if (rd_valid_b !== 1'b0) begin n_bad++; $display("FAIL flush_kills_valid: got %b want 0", rd_valid_b); end
    n_cmp++; if (level_b !== 5'd0) begin n_bad++; $display("FAIL flush_level: got %0d want 0", level_b); end
    n_cmp++; if (empty_b !== 1'b1) begin n_bad++; $display("FAIL flush_empty: got %b want 1", empty_b); end
    n_cmp++; if ({overflow_b, underflow_b} !== 2'b00) begin n_bad++; $display("FAIL flush_flags: got %b want 00", {overflow_b, underflow_b}); end
    step();
    n_cmp++; if (rd_valid_b !== 1'b0) begin n_bad++; $display("FAIL flush_late_valid: got %b want 0", rd_valid_b); end
    n_cmp++; if (rd_data_b !== 16'h3412) begin n_bad++; $display("FAIL flush_rd_data_hold: got %h want 3412", rd_data_b); end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_basic_order();
    test_full_boundary();
    test_empty_boundary();
    test_wrap();
    test_latency_flush();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
